instr_encoder: RTL and testbench

// Packs RV32I instruction fields into 32-bit instruction words. This is the inverse of the opcode

---
 rtl/instr_encoder.sv | 203 ++++++++++++++++++++
 tb/tb_instr_encoder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// instr_encoder
// Packs RV32I instruction fields (format code, opcode, registers, funct fields,
// immediate) into 32-bit instruction words and writes them to instruction
// memory at an auto-incrementing word address. The boot/test loader uses it to
// fill IM before the pipeline is released. Bundles whose format or immediate
// cannot be encoded are dropped and flagged in a sticky error.
//
// Format codes: 000 U, 001 I, 010 S, 011 B, 100 J, 111 R (101/110 illegal).
//
// Parameters
//   ADDR_W     IM word-address width; the address wraps at 2**ADDR_W
//   BASE_ADDR  first IM word address after rst or clr
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   clr        synchronous clear: flush pipe, address back to BASE_ADDR, clear err
//   in_valid   field bundle valid
//   in_ready   encoder accepts the bundle this cycle
//   in_fmt     format code
//   in_op      opcode, bits [6:0] of the word
//   in_rd      destination register
//   in_rs1     source register 1
//   in_rs2     source register 2
//   in_funct3  funct3
//   in_funct7  funct7 (R only)
//   in_imm     signed byte offset / value (U: full 32-bit value)
//   im_we      IM write request
//   im_ready   IM accepts the write this cycle
//   im_addr    IM word address of the current write
//   im_wdata   encoded instruction
//   wr_count   completed writes since rst/clr, saturating at 0xFFFF
//   err        sticky: at least one bundle was dropped
//   err_code   first error: 01 range, 10 misaligned, 11 bad format
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              im_we,
    input  logic              im_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [15:0]       wr_count,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);

    // Bit placement for each instruction format.
    function automatic logic [31:0] f_encode(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (fmt)
            3'b111:  w = {f7, rs2, rs1, f3, rd, op};
            3'b001:  w = {imm[11:0], rs1, f3, rd, op};
            3'b010:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            3'b011:  w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            3'b000:  w = {imm[31:12], rd, op};
            3'b100:  w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Encodability check; earlier branches win (bad format, then alignment,
    // then range). R-type never looks at the immediate.
    function automatic logic [1:0] f_check(
        input logic [2:0]         fmt,
        input logic signed [31:0] imm
    );
        logic [1:0] code;
        code = 2'b00;
        case (fmt)
            3'b101, 3'b110: code = 2'b11;
            3'b001, 3'b010: begin
                if (imm < -32'sd2048 || imm > 32'sd2047) code = 2'b01;
            end
            3'b011: begin
                if (imm[0]) code = 2'b10;
                else if (imm < -32'sd4096 || imm > 32'sd4094) code = 2'b01;
            end
            3'b100: begin
                if (imm[0]) code = 2'b10;
                else if (imm < -32'sd1048576 || imm > 32'sd1048574) code = 2'b01;
            end
            3'b000: begin
                if (imm[11:0] != 12'h000) code = 2'b10;
            end
            default: code = 2'b00;
        endcase
        return code;
    endfunction

    logic              r_s1_vld;
    logic [31:0]       r_s1_word;
    logic [1:0]        r_s1_code;
    logic              r_s2_vld;
    logic [31:0]       r_s2_word;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_cnt;
    logic              r_err;
    logic [1:0]        r_err_code;

    logic        w_wr_done;
    logic        w_s1_adv;
    logic        w_in_fire;
    logic        w_s1_ok;
    logic [31:0] w_enc_word;
    logic [1:0]  w_enc_code;

    assign w_wr_done  = r_s2_vld & im_ready;
    // S2 only stalls while it holds a write the IM has not taken yet.
    assign w_s1_adv   = ~r_s2_vld | w_wr_done;
    assign in_ready   = ~clr & (~r_s1_vld | w_s1_adv);
    assign w_in_fire  = in_valid & in_ready;
    assign w_s1_ok    = (r_s1_code == 2'b00);
    assign w_enc_word = f_encode(in_fmt, in_op, in_rd, in_rs1, in_rs2,
                                 in_funct3, in_funct7, in_imm);
    assign w_enc_code = f_check(in_fmt, $signed(in_imm));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_word  <= 32'h0;
            r_s1_code  <= 2'b00;
            r_s2_vld   <= 1'b0;
            r_s2_word  <= 32'h0;
            r_addr     <= L_BASE;
            r_cnt      <= 16'h0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else if (clr) begin
            r_s1_vld   <= 1'b0;
            r_s1_word  <= 32'h0;
            r_s1_code  <= 2'b00;
            r_s2_vld   <= 1'b0;
            r_s2_word  <= 32'h0;
            r_addr     <= L_BASE;
            r_cnt      <= 16'h0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            // S1: encoded word plus check result
            if (w_in_fire) begin
                r_s1_vld  <= 1'b1;
                r_s1_word <= w_enc_word;
                r_s1_code <= w_enc_code;
            end else if (w_s1_adv) begin
                r_s1_vld  <= 1'b0;
            end

            // S2: IM write; a rejected bundle leaves a bubble instead of a write
            if (w_s1_adv) begin
                r_s2_vld <= r_s1_vld & w_s1_ok;
                if (r_s1_vld & w_s1_ok) r_s2_word <= r_s1_word;
            end

            // Only the first error's code is kept until rst/clr.
            if (w_s1_adv & r_s1_vld & ~w_s1_ok) begin
                r_err <= 1'b1;
                if (!r_err) r_err_code <= r_s1_code;
            end

            if (w_wr_done) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign im_we    = r_s2_vld;
    assign im_wdata = r_s2_word;
    assign im_addr  = r_addr;
    assign wr_count = r_cnt;
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
module tb_instr_encoder;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_fmt = '0;
    logic [6:0]    in_op = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [31:0]   in_imm = '0;
    logic          im_we;
    logic          im_ready = 1'b1;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [15:0]   wr_count;
    logic          err;
    logic [1:0]    err_code;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm),
        .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr),
        .im_wdata(im_wdata), .wr_count(wr_count),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [1:0]  code;
    } evec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   word;
    } exp_t;

    vec_t  tbl [12];
    evec_t etbl [11];
    exp_t  sbq [$];
    int    m_addr = 0;
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every completed write must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && im_we && im_ready) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h", im_addr, im_wdata);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("wr_addr", {30'h0, im_addr}, {30'h0, e.addr});
                chk("wr_data", im_wdata, e.word);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input vec_t v, input bit ok);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        in_fmt = v.fmt; in_op = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stuck 0, required 1");
        end else if (ok) begin
            exp_t e;
            e.addr = AW'(m_addr);
            e.word = v.word;
            sbq.push_back(e);
            m_addr++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d writes pending, required 0", sbq.size());
            sbq.delete();
        end
        tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        chk("in_ready_during_clr", {31'h0, in_ready}, 32'h0);
        tick();
        clr = 1'b0;
        sbq.delete();
        m_addr = 0;
    endtask

    function automatic vec_t mk(input logic [2:0] fmt, input logic [31:0] imm);
        vec_t v;
        v.fmt = fmt; v.op = 7'b0010011; v.rd = 5'd1; v.rs1 = 5'd2; v.rs2 = 5'd3;
        v.f3 = 3'd0; v.f7 = 7'd0; v.imm = imm; v.word = 32'h0;
        return v;
    endfunction

    initial begin
        vec_t v;
        logic [31:0] held;

        //           fmt     op          rd  rs1 rs2 f3 f7         imm            word
        tbl[0]  = '{3'b001, 7'b0010011, 1,  0,  0,  0, 7'h00, 32'd5,         32'h00500093};
        tbl[1]  = '{3'b010, 7'b0100011, 0,  1,  2,  2, 7'h00, 32'd8,         32'h0020A423};
        tbl[2]  = '{3'b011, 7'b1100011, 0,  0,  0,  0, 7'h00, -32'sd4,       32'hFE000EE3};
        tbl[3]  = '{3'b100, 7'b1101111, 1,  0,  0,  0, 7'h00, 32'd8,         32'h008000EF};
        tbl[4]  = '{3'b000, 7'b0110111, 5,  0,  0,  0, 7'h00, 32'h12345000,  32'h123452B7};
        tbl[5]  = '{3'b111, 7'b0110011, 3,  1,  2,  0, 7'h20, 32'hDEADBEEF,  32'h402081B3};
        tbl[6]  = '{3'b001, 7'b0010011, 2,  0,  0,  0, 7'h00, -32'sd2048,    32'h80000113};
        tbl[7]  = '{3'b011, 7'b1100011, 0,  0,  0,  0, 7'h00, 32'd4094,      32'h7E000FE3};
        tbl[8]  = '{3'b100, 7'b1101111, 0,  0,  0,  0, 7'h00, -32'sd1048576, 32'h8000006F};
        tbl[9]  = '{3'b010, 7'b0100011, 0,  0,  0,  2, 7'h00, 32'd2047,      32'h7E002FA3};
        tbl[10] = '{3'b100, 7'b1101111, 0,  0,  0,  0, 7'h00, 32'd1048574,   32'h7FFFF06F};
        tbl[11] = '{3'b000, 7'b0110111, 1,  0,  0,  0, 7'h00, 32'hFFFFF000,  32'hFFFFF0B7};

        etbl[0]  = '{3'b001, 32'd2048,      2'b01};
        etbl[1]  = '{3'b001, -32'sd2049,    2'b01};
        etbl[2]  = '{3'b010, 32'd2048,      2'b01};
        etbl[3]  = '{3'b011, 32'd4096,      2'b01};
        etbl[4]  = '{3'b011, 32'd3,         2'b10};
        etbl[5]  = '{3'b011, 32'd4097,      2'b10};
        etbl[6]  = '{3'b100, 32'd1048576,   2'b01};
        etbl[7]  = '{3'b100, 32'd1,         2'b10};
        etbl[8]  = '{3'b000, 32'h12345001,  2'b10};
        etbl[9]  = '{3'b101, 32'd0,         2'b11};
        etbl[10] = '{3'b110, 32'd7,         2'b11};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_im_we", {31'h0, im_we}, 32'h0);
        chk("rst_im_wdata", im_wdata, 32'h0);
        chk("rst_wr_count", {16'h0, wr_count}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_err_code", {30'h0, err_code}, 32'h0);
        chk("rst_im_addr", {30'h0, im_addr}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_in_ready", {31'h0, in_ready}, 32'h1);
        tick();

        // Table of legal encodings, back to back
        for (int i = 0; i < 12; i++) send(tbl[i], 1'b1);
        drain();
        chk("table_wr_count", {16'h0, wr_count}, 32'd12);
        chk("table_err", {31'h0, err}, 32'h0);

        // Illegal bundles: each dropped with its own first-error code
        for (int i = 0; i < 11; i++) begin
            do_clr();
            send(mk(etbl[i].fmt, etbl[i].imm), 1'b0);
            repeat (4) tick();
            @(negedge clk);
            chk($sformatf("err_flag_%0d", i), {31'h0, err}, 32'h1);
            chk($sformatf("err_code_%0d", i), {30'h0, err_code}, {30'h0, etbl[i].code});
            chk($sformatf("err_addr_%0d", i), {30'h0, im_addr}, 32'h0);
            chk($sformatf("err_count_%0d", i), {16'h0, wr_count}, 32'h0);
            tick();
        end

        // Sticky first code, interleaved with good writes, then clr
        do_clr();
        send(tbl[0], 1'b1);
        send(mk(3'b001, 32'd2048), 1'b0);
        send(tbl[1], 1'b1);
        send(mk(3'b011, 32'd3), 1'b0);
        send(tbl[2], 1'b1);
        drain();
        @(negedge clk);
        chk("sticky_err", {31'h0, err}, 32'h1);
        chk("sticky_code", {30'h0, err_code}, 32'h1);
        chk("sticky_count", {16'h0, wr_count}, 32'd3);
        chk("sticky_addr", {30'h0, im_addr}, 32'd3);
        tick();
        do_clr();
        @(negedge clk);
        chk("clr_err", {31'h0, err}, 32'h0);
        chk("clr_code", {30'h0, err_code}, 32'h0);
        chk("clr_addr", {30'h0, im_addr}, 32'h0);
        chk("clr_count", {16'h0, wr_count}, 32'h0);
        tick();

        // Backpressure: two bundles held in the pipe, third refused until release
        im_ready = 1'b0;
        send(tbl[3], 1'b1);
        send(tbl[4], 1'b1);
        v = tbl[5];
        in_fmt = v.fmt; in_op = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
        in_valid = 1'b1;
        held = tbl[3].word;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
            chk("bp_im_we", {31'h0, im_we}, 32'h1);
            chk("bp_wdata_stable", im_wdata, held);
            chk("bp_addr_stable", {30'h0, im_addr}, 32'h0);
            tick();
        end
        im_ready = 1'b1;
        send(tbl[5], 1'b1);
        drain();
        chk("bp_count", {16'h0, wr_count}, 32'd3);

        // Address wrap with a 2-bit address: fifth write lands at 0
        do_clr();
        for (int i = 0; i < 5; i++) send(tbl[i], 1'b1);
        drain();
        @(negedge clk);
        chk("wrap_count", {16'h0, wr_count}, 32'd5);
        chk("wrap_next_addr", {30'h0, im_addr}, 32'd1);
        chk("wrap_err", {31'h0, err}, 32'h0);
        tick();

        // Asynchronous reset in the middle of a stall
        im_ready = 1'b0;
        send(tbl[6], 1'b1);
        tick();
        @(negedge clk);
        chk("stall_im_we", {31'h0, im_we}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_im_we", {31'h0, im_we}, 32'h0);
        chk("arst_wr_count", {16'h0, wr_count}, 32'h0);
        chk("arst_im_addr", {30'h0, im_addr}, 32'h0);
        sbq.delete();
        m_addr = 0;
        tick();
        rst = 1'b0;
        im_ready = 1'b1;
        tick();
        send(tbl[7], 1'b1);
        drain();
        chk("post_rst_count", {16'h0, wr_count}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
